btn_updown_autorepeat: RTL and testbench
========================================

BTN_UPDOWN_AUTOREPEAT -- requirements
Module: btn_updown_autorepeat

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- DEB_CYCLES, 1_000_000: consecutive stable synchronized cycles needed to accept a level change (10 ms at 100 MHz).
- HOLD_CYCLES, 50_000_000: cycles from press pulse to first repeat pulse (500 ms).
- REP_CYCLES, 10_000_000: cycles between repeat pulses (100 ms).
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- btn_up, in, 1: raw asynchronous up pushbutton, active-high.
- btn_down, in, 1: raw asynchronous down pushbutton, active-high.
- enUP, out, 1: registered one-cycle increment pulse to the minute/second counter.
- enDOWN, out, 1: registered one-cycle decrement pulse to the minute/second counter.
- lvl_up, out, 1: debounced up level.
- lvl_down, out, 1: debounced down level.
REQ-003 Reset is `reset`: synchronous, active-high. Clock is `clk`.

Function
REQ-004 Each raw input SHALL pass through a 2-flop synchronizer before any other logic.
REQ-005 A channel's debounced level SHALL take the synchronized value after that value differs from the current level for exactly DEB_CYCLES consecutive cycles. Any intermediate reversal SHALL clear the stability counter.
REQ-006 Each channel SHALL run an FSM with four states, IDLE, PRESS, HOLD and REPEAT:
- IDLE -> PRESS on debounced rise.
- PRESS lasts 1 cycle, emits one pulse, then goes to HOLD.
- HOLD -> REPEAT after HOLD_CYCLES cycles; REPEAT entry emits one pulse.
- REPEAT emits one pulse every REP_CYCLES cycles.
- Any state other than IDLE -> IDLE on debounced fall, with no pulse emitted.
REQ-007 Press-pulse latency SHALL be exactly DEB_CYCLES+3 cycles from the first clk edge that samples the raw input high.
REQ-008 The first repeat pulse SHALL occur HOLD_CYCLES cycles after the press pulse. Later repeat pulses SHALL occur REP_CYCLES apart.
REQ-009 Each pulse SHALL be exactly 1 cycle high, followed by at least 1 low cycle. REP_CYCLES of 2 or more is required so the downstream rising-edge detector counts every pulse.
REQ-010 While lvl_up and lvl_down are both 1, enUP and enDOWN SHALL both be forced to 0. Both channel FSMs SHALL keep running during this time. Pulses masked this way SHALL be lost, not deferred.
REQ-011 Timer counters SHALL be sized to $clog2(max(DEB_CYCLES, HOLD_CYCLES, REP_CYCLES))+1 bits. A counter SHALL restart at 0 on every FSM state change.
REQ-012 A release SHALL cancel a pending repeat immediately. The debounced fall and a repeat-timer expiry in the same cycle SHALL give no pulse.

Reset
REQ-013 While reset=1 the following SHALL hold:
- enUP, enDOWN, lvl_up and lvl_down are 0.
- Synchronizer flops are 0.
- Both FSMs are in IDLE.
- All counters are 0.
REQ-014 Reset asserted mid-HOLD or mid-REPEAT SHALL abort the FSM with no trailing pulse. A button still held after reset release SHALL re-debounce and give a fresh press pulse per REQ-007.

Structure
REQ-015 A shared package SHALL hold the FSM state encoding (2 bits) and the default cycle constants. The minute/second counters and the debouncers SHALL use the same constants.
REQ-016 One sub-module, btn_autorepeat_ch, SHALL contain the synchronizer, debouncer, FSM and timers for one button. The top SHALL instantiate it twice and add the both-pressed lockout (REQ-010) and the output registers.
REQ-017 The outputs SHALL connect directly to the enUP/enDOWN inputs of the 2-digit BCD 00-59 counter.

Verification
Directed scenarios use DEB_CYCLES=4, HOLD_CYCLES=20 and REP_CYCLES=5.
REQ-018 Clean press: btn_up goes high at edge 0 and is held for 10 cycles -> single enUP pulse at edge 7, lvl_up=1 from edge 6, enDOWN=0 throughout.
REQ-019 Bounce: btn_up toggles every 2 cycles for 12 cycles, then stays high -> no pulse during the bounce; one enUP pulse 7 cycles after the last toggle.
REQ-020 Auto-repeat: btn_down is held for 50 cycles -> enDOWN pulses at edges 7, 27, 32, 37, 42, 47 and 52; none after release is debounced.
REQ-021 Both pressed: btn_up is held, then btn_down rises and both stay high -> no pulse on either output while both lvl are 1. After btn_down releases, enUP repeats resume on the original REP_CYCLES grid.
REQ-022 Reset mid-repeat: reset is pulsed for 1 cycle at edge 30 of a held btn_up -> enUP=0 from edge 31; next enUP pulse at edge 31+7=38, then repeats per REQ-008.
REQ-023 Release race: btn_up is released so that the debounced fall coincides with a repeat-timer expiry -> no enUP pulse in that cycle, and the FSM is in IDLE next cycle.

Source files
------------

// File: rtl/btn_updown_autorepeat_pkg.sv
// rtl/btn_updown_autorepeat_pkg.sv - shared state encoding and cycle constants for button auto-repeat
package btn_updown_autorepeat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } ar_state_t;

  localparam int DEF_DEB_CYCLES  = 1_000_000;
  localparam int DEF_HOLD_CYCLES = 50_000_000;
  localparam int DEF_REP_CYCLES  = 10_000_000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic int ctr_width(input int a, input int b, input int c);
    return $clog2(max3(a, b, c)) + 1;
  endfunction

endpackage

// File: rtl/btn_updown_autorepeat_ch.sv
// rtl/btn_updown_autorepeat_ch.sv - one button channel: synchronizer, debouncer, press/hold/repeat FSM
module btn_autorepeat_ch
  import btn_updown_autorepeat_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int REP_CYCLES  = DEF_REP_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic lvl,
  output logic pulse
);

  localparam int CW = ctr_width(DEB_CYCLES, HOLD_CYCLES, REP_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          lvl_q;
  logic [CW-1:0] deb_cnt;
  logic [CW-1:0] tmr_cnt;
  logic          tmr_clr;
  ar_state_t     state;
  ar_state_t     state_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Level flips only after DEB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_cnt <= '0;
      lvl_q   <= 1'b0;
    end else if (sync2 == lvl_q) begin
      deb_cnt <= '0;
    end else if (deb_cnt == CW'(DEB_CYCLES - 1)) begin
      deb_cnt <= '0;
      lvl_q   <= sync2;
    end else begin
      deb_cnt <= deb_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Every pulse is gated by the current level, so a fall cancels a coincident expiry.
  always_comb begin
    state_nxt = state;
    pulse     = 1'b0;
    tmr_clr   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (lvl_q) state_nxt = ST_PRESS;
      end
      ST_PRESS: begin
        if (!lvl_q) begin
          state_nxt = ST_IDLE;
        end else begin
          pulse     = 1'b1;
          state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (!lvl_q) begin
          state_nxt = ST_IDLE;
        end else if (tmr_cnt == CW'(HOLD_CYCLES - 1)) begin
          pulse     = 1'b1;
          state_nxt = ST_REPEAT;
        end
      end
      ST_REPEAT: begin
        if (!lvl_q) begin
          state_nxt = ST_IDLE;
        end else if (tmr_cnt == CW'(REP_CYCLES - 1)) begin
          pulse   = 1'b1;
          tmr_clr = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || state == ST_IDLE || state_nxt != state || tmr_clr) begin
      tmr_cnt <= '0;
    end else begin
      tmr_cnt <= tmr_cnt + 1'b1;
    end
  end

  assign lvl = lvl_q;

endmodule

// File: rtl/btn_updown_autorepeat.sv
// rtl/btn_updown_autorepeat.sv - up/down button pair with auto-repeat and both-pressed lockout
module btn_updown_autorepeat
  import btn_updown_autorepeat_pkg::*;
#(
  parameter int DEB_CYCLES  = DEF_DEB_CYCLES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int REP_CYCLES  = DEF_REP_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic enUP,
  output logic enDOWN,
  output logic lvl_up,
  output logic lvl_down
);

  logic ch_lvl_up;
  logic ch_lvl_down;
  logic ch_pulse_up;
  logic ch_pulse_down;
  logic lockout;

  btn_autorepeat_ch #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .REP_CYCLES (REP_CYCLES)
  ) u_up (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_up),
    .lvl  (ch_lvl_up),
    .pulse(ch_pulse_up)
  );

  btn_autorepeat_ch #(
    .DEB_CYCLES (DEB_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES),
    .REP_CYCLES (REP_CYCLES)
  ) u_down (
    .clk  (clk),
    .reset(reset),
    .btn  (btn_down),
    .lvl  (ch_lvl_down),
    .pulse(ch_pulse_down)
  );

  // Masked with the same levels that load lvl_up/lvl_down, so outputs stay coherent.
  assign lockout = ch_lvl_up & ch_lvl_down;

  always_ff @(posedge clk) begin
    if (reset) begin
      enUP     <= 1'b0;
      enDOWN   <= 1'b0;
      lvl_up   <= 1'b0;
      lvl_down <= 1'b0;
    end else begin
      enUP     <= ch_pulse_up & ~lockout;
      enDOWN   <= ch_pulse_down & ~lockout;
      lvl_up   <= ch_lvl_up;
      lvl_down <= ch_lvl_down;
    end
  end

endmodule

// File: tb/tb_btn_updown_autorepeat.sv
// tb/tb_btn_updown_autorepeat.sv - directed table and sequence bench for btn_updown_autorepeat
module tb_btn_updown_autorepeat;
  import btn_updown_autorepeat_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic btn_up;
  logic btn_down;
  logic enUP;
  logic enDOWN;
  logic lvl_up;
  logic lvl_down;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic up;
    logic dn;
    logic e_up;
    logic e_dn;
    logic l_up;
    logic l_dn;
  } vec_t;

  vec_t tbl[18];

  btn_updown_autorepeat #(
    .DEB_CYCLES (4),
    .HOLD_CYCLES(20),
    .REP_CYCLES (5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_up  (btn_up),
    .btn_down(btn_down),
    .enUP    (enUP),
    .enDOWN  (enDOWN),
    .lvl_up  (lvl_up),
    .lvl_down(lvl_down)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int k, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d actual=%0b required=%0b", name, k, act, exp);
    end
  endtask

  function automatic logic in_list(input int k, input int q[$]);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  initial begin
    int exp_up[$];
    int exp_dn[$];

    // clean press: held edges 0..9
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    // reset holds everything low even with both buttons pressed
    reset    = 1'b1;
    btn_up   = 1'b1;
    btn_down = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("rst_enUP", k, enUP, 1'b0);
      chk("rst_enDOWN", k, enDOWN, 1'b0);
      chk("rst_lvl_up", k, lvl_up, 1'b0);
      chk("rst_lvl_down", k, lvl_down, 1'b0);
      checks++;
      if (dut.u_up.state != ST_IDLE || dut.u_down.state != ST_IDLE) begin
        errors++;
        $display("FAIL rst_state edge=%0d actual=%0d/%0d required=0/0", k,
                 dut.u_up.state, dut.u_down.state);
      end
    end
    do_reset();

    for (int k = 0; k < 18; k++) begin
      btn_up   = tbl[k].up;
      btn_down = tbl[k].dn;
      step();
      chk("tbl_enUP", k, enUP, tbl[k].e_up);
      chk("tbl_enDOWN", k, enDOWN, tbl[k].e_dn);
      chk("tbl_lvl_up", k, lvl_up, tbl[k].l_up);
      chk("tbl_lvl_down", k, lvl_down, tbl[k].l_dn);
    end
    do_reset();

    // bounce: toggles every 2 cycles, last toggle at edge 12
    exp_up = '{19};
    for (int k = 0; k < 26; k++) begin
      btn_up = (k >= 12) ? 1'b1 : (((k / 2) % 2) == 0);
      step();
      chk("bounce_enUP", k, enUP, in_list(k, exp_up));
      chk("bounce_enDOWN", k, enDOWN, 1'b0);
    end
    do_reset();

    // auto-repeat on down, held edges 0..49
    exp_dn = '{7, 27, 32, 37, 42, 47, 52};
    for (int k = 0; k < 64; k++) begin
      btn_down = (k < 50);
      step();
      chk("rep_enDOWN", k, enDOWN, in_list(k, exp_dn));
      chk("rep_enUP", k, enUP, 1'b0);
    end
    do_reset();

    // both pressed: down held edges 30..44 masks pulses at edges 36..50
    exp_up = '{7, 27, 32, 52, 57};
    for (int k = 0; k < 60; k++) begin
      btn_up   = 1'b1;
      btn_down = (k >= 30 && k < 45);
      step();
      chk("both_enUP", k, enUP, in_list(k, exp_up));
      chk("both_enDOWN", k, enDOWN, 1'b0);
      if (k == 40) begin
        chk("both_lvl_up", k, lvl_up, 1'b1);
        chk("both_lvl_down", k, lvl_down, 1'b1);
      end
    end
    do_reset();

    // reset pulse at edge 30 during repeat
    exp_up = '{7, 27, 38, 58, 63, 68};
    for (int k = 0; k < 70; k++) begin
      btn_up = 1'b1;
      reset  = (k == 30);
      step();
      chk("rstmid_enUP", k, enUP, in_list(k, exp_up));
      if (k == 30) chk("rstmid_lvl_up", k, lvl_up, 1'b0);
    end
    do_reset();

    // release race: debounced fall lands on the repeat expiry for edge 37
    exp_up = '{7, 27, 32};
    for (int k = 0; k < 46; k++) begin
      btn_up = (k < 31);
      step();
      chk("race_enUP", k, enUP, in_list(k, exp_up));
      if (k == 37) begin
        checks++;
        if (dut.u_up.state != ST_IDLE) begin
          errors++;
          $display("FAIL race_state edge=%0d actual=%0d required=%0d", k, dut.u_up.state, ST_IDLE);
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
